dram_port_arbiter: RTL

//  Shares the single dummy-DRAM port between NUM_REQ memory clients (D-cache miss fill,
//  D-cache write-through, I-cache fill). Round-robin grant, one transaction in flight.

---
 rtl/dram_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM port between NUM_REQ memory clients.
// The arbiter uses a round-robin grant and allows one transaction in flight (IDLE -> BUSY -> RESP).
// Optional feature: define DRAM_ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT
// cycles without dram_ready. An aborted transaction signals req_error together with req_ready.
module dram_port_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_error,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [ID_W-1:0]            grant_id,
    output logic                       dram_req,
    output logic                       dram_we,
    output logic [ADDR_W-1:0]          dram_addr,
    output logic [DATA_W-1:0]          dram_wdata,
    input  logic                       dram_ready,
    input  logic [DATA_W-1:0]          dram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_e;

    if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_cfg_check
        $error("dram_port_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
    end

    state_e                 state_q;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        grant_q;
    logic                   dram_req_q;
    logic                   dram_we_q;
    logic [ADDR_W-1:0]      dram_addr_q;
    logic [DATA_W-1:0]      dram_wdata_q;
    logic [NUM_REQ-1:0]     req_ready_q;
    logic [DATA_W-1:0]      req_rdata_q;

    logic                   pick_vld;
    logic [ID_W-1:0]        pick_id;
    logic [ID_W-1:0]        cand;
    logic                   pick_we;
    logic [ADDR_W-1:0]      pick_addr;
    logic [DATA_W-1:0]      pick_wdata;
    logic [NUM_REQ-1:0]     grant_oh;

    assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]       tmo_cnt_q;
    logic [NUM_REQ-1:0]     req_error_q;

    assign req_error = req_error_q;
`else
    assign req_error = '0;
`endif

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping; mux its request fields
    always_comb begin
        pick_vld   = 1'b0;
        pick_id    = '0;
        cand       = '0;
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == pick_id) begin
                pick_we    = req_we[i];
                pick_addr  = req_addr[i*ADDR_W +: ADDR_W];
                pick_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbiter FSM; every output is a register updated on the state transitions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
            req_ready_q  <= '0;
            req_rdata_q  <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            req_error_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant_q      <= pick_id;
                        dram_we_q    <= pick_we;
                        dram_addr_q  <= pick_addr;
                        dram_wdata_q <= pick_wdata;
                        dram_req_q   <= 1'b1;
                        state_q      <= S_BUSY;
`ifdef DRAM_ARB_TIMEOUT_EN
                        tmo_cnt_q    <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    // dram_ready wins over a timeout expiring in the same cycle
                    if (dram_ready) begin
                        if (!dram_we_q) begin
                            req_rdata_q <= dram_rdata;
                        end
                        req_ready_q <= grant_oh;
                        dram_req_q  <= 1'b0;
                        state_q     <= S_RESP;
                    end
`ifdef DRAM_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_LAST) begin
                        req_rdata_q <= '0;
                        req_ready_q <= grant_oh;
                        req_error_q <= grant_oh;
                        dram_req_q  <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    req_ready_q <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
                    req_error_q <= '0;
`endif
                    rr_ptr_q    <= (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign req_rdata  = req_rdata_q;
    assign grant_id   = grant_q;
    assign dram_req   = dram_req_q;
    assign dram_we    = dram_we_q;
    assign dram_addr  = dram_addr_q;
    assign dram_wdata = dram_wdata_q;

endmodule
